// File: rtl/pseudo_spi_frame_rx_if.sv
// Pseudo-SPI receive bus: serial strobes and data in, latched frame and status out.
interface pseudo_spi_frame_rx_if #(
  parameter int FRAME_WIDTH = 64,
  parameter int CNT_WIDTH   = 12
);
  logic                   SCLK1;
  logic                   SCLK2;
  logic                   LAT;
  logic                   SPI_SO;
  logic                   ERR_CLR;
  logic [FRAME_WIDTH-1:0] DOUT;
  logic [CNT_WIDTH-1:0]   DOUT_BITS;
  logic                   DOUT_VLD;
  logic                   BUSY;
  logic                   OVF;
  logic                   PHASE_ERR;

  modport master (
    output SCLK1, SCLK2, LAT, SPI_SO, ERR_CLR,
    input  DOUT, DOUT_BITS, DOUT_VLD, BUSY, OVF, PHASE_ERR
  );

  modport slave (
    input  SCLK1, SCLK2, LAT, SPI_SO, ERR_CLR,
    output DOUT, DOUT_BITS, DOUT_VLD, BUSY, OVF, PHASE_ERR
  );
endinterface

// File: rtl/pseudo_spi_frame_rx.sv
// Oversampling receiver for the two-phase pseudo-SPI stream; deserialises bits and latches frames on LAT.
//   state    | meaning
//   IDLE_BIT | no bit captured, waiting for SCLK1 rise
//   PENDING  | bit captured on SCLK1, waiting for SCLK2 rise to commit it
module pseudo_spi_frame_rx #(
  parameter int FRAME_WIDTH = 64,
  parameter int CNT_WIDTH   = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic                 CLK,
  input logic                 RST,
  pseudo_spi_frame_rx_if.slave bus
);

  typedef enum logic {IDLE_BIT, PENDING} bit_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] FW_CNT  = CNT_WIDTH'(FRAME_WIDTH);

  // {LAT, SCLK2, SCLK1, SPI_SO}: data shares the strobe pipeline to stay aligned
  logic [3:0] pin_vec;
  logic [3:0] sync_vec;

  assign pin_vec = {bus.LAT, bus.SCLK2, bus.SCLK1, bus.SPI_SO};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sync_vec = pin_vec;
    end else begin : g_sync
      logic [3:0] sync_q [SYNC_STAGES];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= pin_vec;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sync_vec = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // rise_q: [0]=SCLK1, [1]=SCLK2, [2]=LAT; registered so each rise acts one edge later
  logic [2:0] strb_prev;
  logic [2:0] rise_q;
  logic       so_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      strb_prev <= '0;
      rise_q    <= '0;
      so_q      <= 1'b0;
    end else begin
      strb_prev <= sync_vec[3:1];
      rise_q    <= sync_vec[3:1] & ~strb_prev;
      so_q      <= sync_vec[0];
    end
  end

  logic s1_rise, s2_rise, lat_rise;
  assign s1_rise  = rise_q[0];
  assign s2_rise  = rise_q[1];
  assign lat_rise = rise_q[2];

  bit_state_t             state, state_nx;
  logic [FRAME_WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_WIDTH-1:0]   bit_cnt, cnt_nx;
  logic                   pend_bit, pend_nx;
  logic                   load, ovf_set, perr_set;

  logic [FRAME_WIDTH-1:0] dout;
  logic [CNT_WIDTH-1:0]   dout_bits;
  logic                   dout_vld, busy, ovf, phase_err;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    pend_nx  = pend_bit;
    load     = 1'b0;
    ovf_set  = 1'b0;
    perr_set = 1'b0;
    if (lat_rise) begin
      load     = (bit_cnt != '0);
      state_nx = IDLE_BIT;
      shreg_nx = '0;
      cnt_nx   = '0;
      pend_nx  = 1'b0;
    end else if (s1_rise && s2_rise) begin
      perr_set = 1'b1;
    end else begin
      case (state)
        IDLE_BIT: begin
          if (s1_rise) begin
            pend_nx  = so_q;
            state_nx = PENDING;
          end else if (s2_rise) begin
            perr_set = 1'b1;
          end
        end
        PENDING: begin
          if (s2_rise) begin
            shreg_nx = {shreg[FRAME_WIDTH-2:0], pend_bit};
            if (bit_cnt != CNT_MAX) cnt_nx = bit_cnt + 1'b1;
            ovf_set  = (bit_cnt >= FW_CNT);
            state_nx = IDLE_BIT;
          end else if (s1_rise) begin
            perr_set = 1'b1;
            pend_nx  = so_q;
          end
        end
        default: state_nx = IDLE_BIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE_BIT;
      shreg     <= '0;
      bit_cnt   <= '0;
      pend_bit  <= 1'b0;
      dout      <= '0;
      dout_bits <= '0;
      dout_vld  <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      phase_err <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= cnt_nx;
      pend_bit  <= pend_nx;
      dout_vld  <= load;
      if (load) begin
        dout      <= shreg;
        dout_bits <= bit_cnt;
      end
      busy      <= (cnt_nx != '0) | (state_nx == PENDING);
      ovf       <= ovf_set | (ovf & ~bus.ERR_CLR);
      phase_err <= perr_set | (phase_err & ~bus.ERR_CLR);
    end
  end

  assign bus.DOUT      = dout;
  assign bus.DOUT_BITS = dout_bits;
  assign bus.DOUT_VLD  = dout_vld;
  assign bus.BUSY      = busy;
  assign bus.OVF       = ovf;
  assign bus.PHASE_ERR = phase_err;

endmodule

// File: tb/tb_pseudo_spi_frame_rx.sv
// Bench for pseudo_spi_frame_rx: event-level model checked every cycle plus directed literal expectations.
module tb_pseudo_spi_frame_rx;
  localparam int FW = 64;
  localparam int CW = 12;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk1 = 1'b0, sclk2 = 1'b0, lat = 1'b0, so = 1'b0, err_clr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  pseudo_spi_frame_rx_if #(.FRAME_WIDTH(FW), .CNT_WIDTH(CW)) bus2();
  pseudo_spi_frame_rx_if #(.FRAME_WIDTH(FW), .CNT_WIDTH(CW)) bus0();

  assign bus2.SCLK1 = sclk1;  assign bus0.SCLK1 = sclk1;
  assign bus2.SCLK2 = sclk2;  assign bus0.SCLK2 = sclk2;
  assign bus2.LAT = lat;      assign bus0.LAT = lat;
  assign bus2.SPI_SO = so;    assign bus0.SPI_SO = so;
  assign bus2.ERR_CLR = err_clr; assign bus0.ERR_CLR = err_clr;

  pseudo_spi_frame_rx #(.FRAME_WIDTH(FW), .CNT_WIDTH(CW), .SYNC_STAGES(S)) dut2 (
    .CLK(clk), .RST(rst), .bus(bus2));
  pseudo_spi_frame_rx #(.FRAME_WIDTH(FW), .CNT_WIDTH(CW), .SYNC_STAGES(0)) dut0 (
    .CLK(clk), .RST(rst), .bus(bus0));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model of the SYNC_STAGES=2 instance: pin history delay line, committed bits in a queue
  bit [7:0]    h_s1, h_s2, h_lat, h_so;
  bit          q[$];
  bit          m_pend, m_pval, m_vld, m_busy, m_ovf, m_perr;
  logic [63:0] m_dout;
  int          m_bits;

  function automatic logic [63:0] pack_last();
    logic [63:0] d = '0;
    int n = q.size();
    int first = (n > FW) ? n - FW : 0;
    for (int i = first; i < n; i++) d = {d[62:0], q[i]};
    return d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h_s1 = '0; h_s2 = '0; h_lat = '0; h_so = '0;
      q.delete();
      m_pend = 0; m_pval = 0; m_vld = 0; m_busy = 0; m_ovf = 0; m_perr = 0;
      m_dout = '0; m_bits = 0;
    end else begin
      bit r1, r2, rl, d, ovf_set, perr_set;
      h_s1  = {h_s1[6:0], sclk1};
      h_s2  = {h_s2[6:0], sclk2};
      h_lat = {h_lat[6:0], lat};
      h_so  = {h_so[6:0], so};
      r1 = h_s1[S+1] & ~h_s1[S+2];
      r2 = h_s2[S+1] & ~h_s2[S+2];
      rl = h_lat[S+1] & ~h_lat[S+2];
      d  = h_so[S+1];
      m_vld = 0; ovf_set = 0; perr_set = 0;
      if (rl) begin
        if (q.size() > 0) begin
          m_dout = pack_last();
          m_bits = (q.size() > 4095) ? 4095 : q.size();
          m_vld  = 1;
        end
        q.delete();
        m_pend = 0;
      end else if (r1 && r2) begin
        perr_set = 1;
      end else if (m_pend) begin
        if (r2) begin
          q.push_back(m_pval);
          m_pend = 0;
          if (q.size() > FW) ovf_set = 1;
        end else if (r1) begin
          perr_set = 1;
          m_pval = d;
        end
      end else begin
        if (r1) begin
          m_pend = 1;
          m_pval = d;
        end else if (r2) begin
          perr_set = 1;
        end
      end
      m_ovf  = ovf_set | (m_ovf & ~err_clr);
      m_perr = perr_set | (m_perr & ~err_clr);
      m_busy = (q.size() > 0) || m_pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_dout", bus2.DOUT, m_dout);
      chk("cyc_dout_bits", 64'(bus2.DOUT_BITS), 64'(m_bits));
      chk("cyc_dout_vld", 64'(bus2.DOUT_VLD), 64'(m_vld));
      chk("cyc_busy", 64'(bus2.BUSY), 64'(m_busy));
      chk("cyc_ovf", 64'(bus2.OVF), 64'(m_ovf));
      chk("cyc_phase_err", 64'(bus2.PHASE_ERR), 64'(m_perr));
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    so = b; sclk1 = 1; tick(2);
    sclk1 = 0; tick(1);
    sclk2 = 1; tick(2);
    sclk2 = 0; tick(1);
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Raise LAT and report how many edges after first sampling each instance pulses DOUT_VLD
  task automatic lat_timed(output int e2, output int e0, output int n2);
    e2 = -1; e0 = -1; n2 = 0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus2.DOUT_VLD) begin n2++; if (e2 < 0) e2 = i; end
      if (bus0.DOUT_VLD && e0 < 0) e0 = i;
    end
    @(negedge clk);
    lat = 0;
    tick(3);
  endtask

  task automatic clr_errs();
    err_clr = 1; tick(1);
    err_clr = 0; tick(2);
  endtask

  int e2, e0, n2, vcnt;

  initial begin
    tick(3);
    cmp_en = 1;
    chk("rst_dout", bus2.DOUT, 64'h0);
    chk("rst_busy", 64'(bus2.BUSY), 64'h0);
    chk("rst_flags", 64'({bus2.OVF, bus2.PHASE_ERR, bus2.DOUT_VLD}), 64'h0);
    rst = 0;
    tick(4);

    send_byte(8'hA5);
    lat_timed(e2, e0, n2);
    chk("a5_dout", bus2.DOUT, 64'h00000000000000A5);
    chk("a5_bits", 64'(bus2.DOUT_BITS), 64'd8);
    chk("a5_vld_edges_s2", 64'(e2), 64'd3);
    chk("a5_vld_edges_s0", 64'(e0), 64'd1);
    chk("a5_vld_count", 64'(n2), 64'd1);
    chk("a5_s0_dout", bus0.DOUT, 64'h00000000000000A5);
    chk("a5_flags", 64'({bus2.OVF, bus2.PHASE_ERR}), 64'h0);

    lat_timed(e2, e0, n2);
    chk("empty_vld_count", 64'(n2), 64'd0);
    chk("empty_dout_kept", bus2.DOUT, 64'h00000000000000A5);
    chk("empty_bits_kept", 64'(bus2.DOUT_BITS), 64'd8);

    for (int b = 1; b <= 9; b++) send_byte(8'(b));
    lat_timed(e2, e0, n2);
    chk("ovf_dout", bus2.DOUT, 64'h0203040506070809);
    chk("ovf_bits", 64'(bus2.DOUT_BITS), 64'd72);
    chk("ovf_set", 64'(bus2.OVF), 64'd1);
    chk("ovf_s0_dout", bus0.DOUT, 64'h0203040506070809);
    clr_errs();
    chk("ovf_cleared", 64'(bus2.OVF), 64'd0);

    sclk2 = 1; tick(2); sclk2 = 0; tick(2);
    sclk1 = 1; sclk2 = 1; tick(2); sclk1 = 0; sclk2 = 0; tick(4);
    chk("phase_err_set", 64'(bus2.PHASE_ERR), 64'd1);
    chk("phase_busy", 64'(bus2.BUSY), 64'd0);
    clr_errs();
    chk("phase_err_cleared", 64'(bus2.PHASE_ERR), 64'd0);

    send_bit(1); send_bit(0); send_bit(1);
    so = 1; sclk1 = 1; tick(2); sclk1 = 0; tick(3);
    chk("pend_busy", 64'(bus2.BUSY), 64'd1);
    lat_timed(e2, e0, n2);
    chk("pend_dout", bus2.DOUT, 64'h5);
    chk("pend_bits", 64'(bus2.DOUT_BITS), 64'd3);
    chk("pend_busy_after", 64'(bus2.BUSY), 64'd0);
    chk("pend_phase_err", 64'(bus2.PHASE_ERR), 64'd0);

    send_bit(1); send_bit(1); send_bit(0); send_bit(1);
    chk("mid_busy", 64'(bus2.BUSY), 64'd1);
    rst = 1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus2.DOUT_VLD || bus0.DOUT_VLD) vcnt++;
    end
    @(negedge clk);
    chk("mid_rst_vld", 64'(vcnt), 64'd0);
    chk("mid_rst_dout", bus2.DOUT, 64'h0);
    chk("mid_rst_bits", 64'(bus2.DOUT_BITS), 64'd0);
    chk("mid_rst_busy", 64'(bus2.BUSY), 64'd0);
    chk("mid_rst_s0_dout", bus0.DOUT, 64'h0);
    rst = 0;
    tick(5);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
